// File: rtl/wb_exc_commit_pkg.sv
// Shared WB/CP0 definitions: bus layout, exception codes, CP0 register numbers and the WB state.
// Imported by the writeback commit unit and its interrupt detector.
package wb_exc_commit_pkg;

   localparam int unsigned WB_TO_CP0_REGISTER_BUS_WD = 110;

   // Status.BEV is hard-wired to 1, so the general exception entry lives in the boot ROM.
   localparam logic [31:0] EX_VECTOR = 32'hBFC0_0380;

   localparam logic [4:0] EX_INT  = 5'h00;
   localparam logic [4:0] EX_ADEL = 5'h04;
   localparam logic [4:0] EX_ADES = 5'h05;
   localparam logic [4:0] EX_SYS  = 5'h08;
   localparam logic [4:0] EX_BP   = 5'h09;
   localparam logic [4:0] EX_RI   = 5'h0a;
   localparam logic [4:0] EX_OV   = 5'h0c;

   localparam logic [4:0] CR_BADVADDR = 5'd8;
   localparam logic [4:0] CR_COUNT    = 5'd9;
   localparam logic [4:0] CR_COMPARE  = 5'd11;
   localparam logic [4:0] CR_STATUS   = 5'd12;
   localparam logic [4:0] CR_CAUSE    = 5'd13;
   localparam logic [4:0] CR_EPC      = 5'd14;

   typedef enum logic {
      StRun,
      StFlush
   } ws_state_e;

   // Field order is MSB first and must match the CP0 register file's unpacking.
   typedef struct packed {
      logic        ex;
      logic [4:0]  excode;
      logic [31:0] badvaddr;
      logic        bd;
      logic [31:0] pc;
      logic        mtc0_we;
      logic [4:0]  c0_waddr;
      logic [31:0] c0_wdata;
      logic        eret_flush;
   } wb_cp0_bus_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        ex;
      logic [4:0]  excode;
      logic [31:0] badvaddr;
      logic        bd;
      logic        mtc0;
      logic        mfc0;
      logic        eret;
      logic [4:0]  c0_addr;
      logic [31:0] rt_value;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
   } ws_ctx_t;

   // Interrupt lines that are both raised in Cause.IP and enabled in Status.IM.
   function automatic logic [7:0] irq_lines(input logic [31:0] status, input logic [31:0] cause);
      return cause[15:8] & status[15:8];
   endfunction

endpackage

// File: rtl/wb_int_detect.sv
// Combinational interrupt detection on CP0 Status/Cause readback and merge of the exception code.
// An enabled interrupt outranks whatever exception the instruction carried from upstream.
module wb_int_detect
   import wb_exc_commit_pkg::*;
(
   input  logic [31:0] i_status,
   input  logic [31:0] i_cause,
   input  logic [4:0]  i_ws_excode,
   output logic        o_int_pend,
   output logic [4:0]  o_excode
);

   logic w_ie;
   logic w_exl;
   logic w_unused;

   assign w_ie  = i_status[0];
   assign w_exl = i_status[1];

   assign o_int_pend = w_ie & ~w_exl & (|irq_lines(i_status, i_cause));
   assign o_excode   = o_int_pend ? EX_INT : i_ws_excode;

   assign w_unused = ^{i_status[31:16], i_status[7:2], i_cause[31:16], i_cause[7:0]};

endmodule

// File: rtl/wb_exc_commit.sv
// Writeback commit: holds the WB pipeline register, merges exceptions with pending interrupts,
// drives the WB-to-CP0 bus, pipeline flush/redirect and the GPR writeback port.
module wb_exc_commit
   import wb_exc_commit_pkg::*;
#(
   parameter logic [31:0] EX_VECTOR = wb_exc_commit_pkg::EX_VECTOR
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 ms_to_ws_valid,
   output logic                                 ws_allow_in,
   input  logic [31:0]                          ms_pc,
   input  logic                                 ms_ex,
   input  logic [4:0]                           ms_excode,
   input  logic [31:0]                          ms_badvaddr,
   input  logic                                 ms_bd,
   input  logic                                 ms_mtc0,
   input  logic                                 ms_mfc0,
   input  logic                                 ms_eret,
   input  logic [4:0]                           ms_c0_addr,
   input  logic [31:0]                          ms_rt_value,
   input  logic                                 ms_gr_we,
   input  logic [4:0]                           ms_dest,
   input  logic [31:0]                          ms_result,
   input  logic [31:0]                          cp0_rdata,
   input  logic [31:0]                          cp0_epc,
   input  logic [31:0]                          cp0_status,
   input  logic [31:0]                          cp0_cause,
   output logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_register_bus,
   output logic                                 rf_we,
   output logic [4:0]                           rf_waddr,
   output logic [31:0]                          rf_wdata,
   output logic                                 ws_flush,
   output logic [31:0]                          ws_flush_pc,
   output logic [31:0]                          debug_wb_pc
);

   ws_state_e   r_state;
   logic        r_ws_valid;
   ws_ctx_t     r_ws;

   logic        w_int_pend;
   logic [4:0]  w_excode;
   logic        w_take_ex;
   logic        w_eret_flush;
   logic        w_mtc0_we;
   wb_cp0_bus_t w_bus;

   wb_int_detect u_int_detect (
      .i_status    (cp0_status),
      .i_cause     (cp0_cause),
      .i_ws_excode (r_ws.excode),
      .o_int_pend  (w_int_pend),
      .o_excode    (w_excode)
   );

   assign w_take_ex    = r_ws_valid & (w_int_pend | r_ws.ex);
   assign w_eret_flush = r_ws_valid & r_ws.eret & ~w_take_ex;
   assign w_mtc0_we    = r_ws_valid & r_ws.mtc0 & ~w_take_ex;

   assign ws_allow_in = (r_state == StRun);
   assign ws_flush    = w_take_ex | w_eret_flush;

   always_comb begin
      w_bus            = '0;
      w_bus.ex         = w_take_ex;
      w_bus.excode     = w_excode;
      w_bus.badvaddr   = r_ws.badvaddr;
      w_bus.bd         = r_ws.bd;
      w_bus.pc         = r_ws.pc;
      w_bus.mtc0_we    = w_mtc0_we;
      w_bus.c0_waddr   = r_ws.c0_addr;
      w_bus.c0_wdata   = r_ws.rt_value;
      w_bus.eret_flush = w_eret_flush;
   end

   assign wb_to_cp0_register_bus = w_bus;

   always_comb begin
      ws_flush_pc = 32'h0;
      if (w_take_ex) begin
         ws_flush_pc = EX_VECTOR;
      end else if (w_eret_flush) begin
         ws_flush_pc = cp0_epc;
      end
   end

   assign rf_we       = r_ws_valid & r_ws.gr_we & ~w_take_ex;
   assign rf_waddr    = r_ws.dest;
   assign rf_wdata    = r_ws.mfc0 ? cp0_rdata : r_ws.result;
   assign debug_wb_pc = r_ws.pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StRun;
         r_ws_valid <= 1'b0;
         r_ws       <= '0;
      end else begin
         unique case (r_state)
            StRun: begin
               if (ws_flush) begin
                  r_state <= StFlush;
               end
               // Whatever MEM offers alongside a flush is younger and must be killed.
               if (ms_to_ws_valid && !ws_flush) begin
                  r_ws_valid      <= 1'b1;
                  r_ws.pc         <= ms_pc;
                  r_ws.ex         <= ms_ex;
                  r_ws.excode     <= ms_excode;
                  r_ws.badvaddr   <= ms_badvaddr;
                  r_ws.bd         <= ms_bd;
                  r_ws.mtc0       <= ms_mtc0;
                  r_ws.mfc0       <= ms_mfc0;
                  r_ws.eret       <= ms_eret;
                  r_ws.c0_addr    <= ms_c0_addr;
                  r_ws.rt_value   <= ms_rt_value;
                  r_ws.gr_we      <= ms_gr_we;
                  r_ws.dest       <= ms_dest;
                  r_ws.result     <= ms_result;
               end else begin
                  r_ws_valid <= 1'b0;
               end
            end
            StFlush: begin
               r_state    <= StRun;
               r_ws_valid <= 1'b0;
            end
            default: begin
               r_state    <= StRun;
               r_ws_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_exc_commit.sv
// Self-checking bench for wb_exc_commit: directed vector table, hand-written flush/reset sequences
// and a randomized run against a behavioural model of the commit rules.
module tb_wb_exc_commit;
   import wb_exc_commit_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         ms_to_ws_valid;
   logic         ws_allow_in;
   logic [31:0]  ms_pc;
   logic         ms_ex;
   logic [4:0]   ms_excode;
   logic [31:0]  ms_badvaddr;
   logic         ms_bd;
   logic         ms_mtc0;
   logic         ms_mfc0;
   logic         ms_eret;
   logic [4:0]   ms_c0_addr;
   logic [31:0]  ms_rt_value;
   logic         ms_gr_we;
   logic [4:0]   ms_dest;
   logic [31:0]  ms_result;
   logic [31:0]  cp0_rdata;
   logic [31:0]  cp0_epc;
   logic [31:0]  cp0_status;
   logic [31:0]  cp0_cause;
   logic [109:0] bus;
   logic         rf_we;
   logic [4:0]   rf_waddr;
   logic [31:0]  rf_wdata;
   logic         ws_flush;
   logic [31:0]  ws_flush_pc;
   logic [31:0]  debug_wb_pc;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   wb_exc_commit dut (
      .clk                    (clk),
      .reset                  (reset),
      .ms_to_ws_valid         (ms_to_ws_valid),
      .ws_allow_in            (ws_allow_in),
      .ms_pc                  (ms_pc),
      .ms_ex                  (ms_ex),
      .ms_excode              (ms_excode),
      .ms_badvaddr            (ms_badvaddr),
      .ms_bd                  (ms_bd),
      .ms_mtc0                (ms_mtc0),
      .ms_mfc0                (ms_mfc0),
      .ms_eret                (ms_eret),
      .ms_c0_addr             (ms_c0_addr),
      .ms_rt_value            (ms_rt_value),
      .ms_gr_we               (ms_gr_we),
      .ms_dest                (ms_dest),
      .ms_result              (ms_result),
      .cp0_rdata              (cp0_rdata),
      .cp0_epc                (cp0_epc),
      .cp0_status             (cp0_status),
      .cp0_cause              (cp0_cause),
      .wb_to_cp0_register_bus (bus),
      .rf_we                  (rf_we),
      .rf_waddr               (rf_waddr),
      .rf_wdata               (rf_wdata),
      .ws_flush               (ws_flush),
      .ws_flush_pc            (ws_flush_pc),
      .debug_wb_pc            (debug_wb_pc)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic        ex;
      logic [4:0]  excode;
      logic [31:0] badv;
      logic        bd, mtc0, mfc0, eret;
      logic [4:0]  c0a;
      logic [31:0] rt;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result, status, cause, epc, rdata;
      logic        e_ex;
      logic [4:0]  e_excode;
      logic        e_mtc0, e_eret, e_rf_we;
      logic [31:0] e_rf_wdata;
      logic        e_flush;
      logic [31:0] e_flush_pc;
   } vec_t;

   function automatic vec_t mk(
      input logic [31:0] pc, input logic ex, input logic [4:0] excode, input logic [31:0] badv,
      input logic bd, input logic mtc0, input logic mfc0, input logic eret,
      input logic [4:0] c0a, input logic [31:0] rt, input logic gr_we, input logic [4:0] dest,
      input logic [31:0] result, input logic [31:0] status, input logic [31:0] cause,
      input logic [31:0] epc, input logic [31:0] rdata,
      input logic e_ex, input logic [4:0] e_excode, input logic e_mtc0, input logic e_eret,
      input logic e_rf_we, input logic [31:0] e_rf_wdata, input logic e_flush,
      input logic [31:0] e_flush_pc);
      vec_t v;
      v.pc = pc; v.ex = ex; v.excode = excode; v.badv = badv; v.bd = bd;
      v.mtc0 = mtc0; v.mfc0 = mfc0; v.eret = eret; v.c0a = c0a; v.rt = rt;
      v.gr_we = gr_we; v.dest = dest; v.result = result;
      v.status = status; v.cause = cause; v.epc = epc; v.rdata = rdata;
      v.e_ex = e_ex; v.e_excode = e_excode; v.e_mtc0 = e_mtc0; v.e_eret = e_eret;
      v.e_rf_we = e_rf_we; v.e_rf_wdata = e_rf_wdata; v.e_flush = e_flush;
      v.e_flush_pc = e_flush_pc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      ms_pc = v.pc; ms_ex = v.ex; ms_excode = v.excode; ms_badvaddr = v.badv; ms_bd = v.bd;
      ms_mtc0 = v.mtc0; ms_mfc0 = v.mfc0; ms_eret = v.eret; ms_c0_addr = v.c0a;
      ms_rt_value = v.rt; ms_gr_we = v.gr_we; ms_dest = v.dest; ms_result = v.result;
      cp0_status = v.status; cp0_cause = v.cause; cp0_epc = v.epc; cp0_rdata = v.rdata;
   endtask

   task automatic cp0_idle();
      cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0; cp0_rdata = 32'h0;
   endtask

   // Behavioural model: the instruction sitting in WB plus "previous cycle was a flush".
   vec_t m;
   bit   m_valid;
   bit   m_flushing;

   bit           p_take, p_eret, p_mtc0, p_flush, p_rf_we;
   logic [4:0]   p_excode;
   logic [31:0]  p_fpc, p_rf_wdata;
   logic [109:0] p_bus;

   task automatic predict();
      bit hit = 0;
      bit irq;
      for (int k = 8; k < 16; k++) if (cp0_status[k] && cp0_cause[k]) hit = 1;
      irq      = cp0_status[0] && !cp0_status[1] && hit;
      p_take   = m_valid && (irq || m.ex);
      p_excode = irq ? EX_INT : m.excode;
      p_eret   = m_valid && m.eret && !p_take;
      p_mtc0   = m_valid && m.mtc0 && !p_take;
      p_flush  = p_take || p_eret;
      p_fpc    = p_take ? 32'hBFC0_0380 : (p_eret ? cp0_epc : 32'h0);
      p_rf_we  = m_valid && m.gr_we && !p_take;
      p_rf_wdata = m.mfc0 ? cp0_rdata : m.result;
      p_bus = {p_take, p_excode, m.badv, m.bd, m.pc, p_mtc0, m.c0a, m.rt, p_eret};
   endtask

   task automatic model_edge();
      if (reset) begin
         m = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         m_valid = 0;
         m_flushing = 0;
      end else if (m_flushing) begin
         m_flushing = 0;
         m_valid = 0;
      end else begin
         predict();
         if (ms_to_ws_valid && !p_flush) begin
            m.pc = ms_pc; m.ex = ms_ex; m.excode = ms_excode; m.badv = ms_badvaddr;
            m.bd = ms_bd; m.mtc0 = ms_mtc0; m.mfc0 = ms_mfc0; m.eret = ms_eret;
            m.c0a = ms_c0_addr; m.rt = ms_rt_value; m.gr_we = ms_gr_we; m.dest = ms_dest;
            m.result = ms_result;
            m_valid = 1;
         end else begin
            m_valid = 0;
         end
         m_flushing = p_flush;
      end
   endtask

   vec_t vecs[$];
   vec_t drop_v;
   vec_t idle_v;
   vec_t sys_v;

   initial begin
      idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drop_v = mk(32'hBFC0_0BAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hBAD, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0);
      sys_v  = mk(32'hBFC0_0020, 1, EX_SYS, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  1, EX_SYS, 0, 0, 0, 0, 1, 32'hBFC0_0380);
      // ADDU
      vecs.push_back(mk(32'hBFC0_0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 0,
                        0, 0, 0, 0, 1, 32'h1234, 0, 0));
      vecs.push_back(sys_v);
      // ERET
      vecs.push_back(mk(32'hBFC0_0030, 0, 0, 0, 0, 0, 0, 1, CR_EPC, 0, 0, 0, 0, 0, 0,
                        32'hBFC0_1000, 0, 0, 0, 0, 1, 0, 0, 1, 32'hBFC0_1000));
      // MTC0 under a pending interrupt; upstream code RI must be replaced by INT
      vecs.push_back(mk(32'hBFC0_0040, 0, EX_RI, 0, 0, 1, 0, 0, CR_STATUS, 32'hA5, 0, 0, 0,
                        32'h0000_8001, 32'h0000_8000, 0, 0, 1, EX_INT, 0, 0, 0, 0, 1,
                        32'hBFC0_0380));
      // Same but EXL set: no interrupt
      vecs.push_back(mk(32'hBFC0_0050, 0, 0, 0, 0, 1, 0, 0, CR_STATUS, 32'hA5, 0, 0, 0,
                        32'h0000_8003, 32'h0000_8000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      // MFC0 COUNT
      vecs.push_back(mk(32'hBFC0_0060, 0, 0, 0, 0, 0, 1, 0, CR_COUNT, 0, 1, 3, 32'hDEAD, 0, 0,
                        0, 32'h55, 0, 0, 0, 0, 1, 32'h55, 0, 0));
      // ADES together with ERET: exception wins
      vecs.push_back(mk(32'hBFC0_0070, 1, EX_ADES, 32'h1003, 0, 0, 0, 1, 0, 0, 1, 4, 32'h77,
                        0, 0, 32'hBFC0_1000, 0, 1, EX_ADES, 0, 0, 0, 32'h77, 1,
                        32'hBFC0_0380));
      // IP and IM on different lines
      vecs.push_back(mk(32'hBFC0_0080, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h99,
                        32'h0000_0401, 32'h0000_0800, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0));
      // Interrupt outranks overflow
      vecs.push_back(mk(32'hBFC0_0090, 1, EX_OV, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h1,
                        32'h0000_0101, 32'h0000_0100, 0, 0, 1, EX_INT, 0, 0, 0, 32'h1, 1,
                        32'hBFC0_0380));
      // IE clear: no interrupt
      vecs.push_back(mk(32'hBFC0_00A0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h42,
                        32'h0000_0100, 32'h0000_0100, 0, 0, 0, 0, 0, 0, 1, 32'h42, 0, 0));

      reset = 1'b1;
      ms_to_ws_valid = 1'b0;
      drive(idle_v);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_allow_in", ws_allow_in, 1'b1);
      chk("reset_bus", bus, 110'h0);
      chk("reset_rf", {rf_we, rf_waddr, rf_wdata}, 38'h0);
      chk("reset_flush", {ws_flush, ws_flush_pc, debug_wb_pc}, 65'h0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i]);
         ms_to_ws_valid = 1'b1;
         @(posedge clk); #1;
         ms_to_ws_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d_bus", i), bus,
             {vecs[i].e_ex, vecs[i].e_excode, vecs[i].badv, vecs[i].bd, vecs[i].pc,
              vecs[i].e_mtc0, vecs[i].c0a, vecs[i].rt, vecs[i].e_eret});
         chk($sformatf("vec%0d_rf", i), {rf_we, rf_waddr, rf_wdata},
             {vecs[i].e_rf_we, vecs[i].dest, vecs[i].e_rf_wdata});
         chk($sformatf("vec%0d_flush", i), {ws_flush, ws_flush_pc},
             {vecs[i].e_flush, vecs[i].e_flush_pc});
         chk($sformatf("vec%0d_dbg", i), {ws_allow_in, debug_wb_pc}, {1'b1, vecs[i].pc});
         if (vecs[i].e_flush) begin
            @(posedge clk); #1;
            drive(drop_v);
            cp0_idle();
            ms_to_ws_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_flushcyc", i), {ws_allow_in, ws_flush, bus[109], bus[38],
                bus[0]}, 5'b0);
            @(posedge clk); #1;
            ms_to_ws_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_dropped", i), {ws_allow_in, rf_we}, 2'b10);
         end else begin
            cp0_idle();
            @(posedge clk); #1;
         end
      end

      // Reset asserted during the flush cycle
      drive(sys_v);
      ms_to_ws_valid = 1'b1;
      @(posedge clk); #1;
      ms_to_ws_valid = 1'b0;
      @(negedge clk);
      chk("rstfl_flush", ws_flush, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstfl_in_flush", ws_allow_in, 1'b0);
      reset = 1'b1;
      drive(drop_v);
      ms_to_ws_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstfl_allow_in", ws_allow_in, 1'b1);
      chk("rstfl_bus", bus, 110'h0);
      chk("rstfl_out", {rf_we, ws_flush, ws_flush_pc}, 34'h0);
      ms_to_ws_valid = 1'b0;

      // Randomized run; reset is still high for the first edge so the model starts aligned
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         reset          = ($urandom_range(0, 39) == 0);
         ms_to_ws_valid = ($urandom_range(0, 3) != 0);
         ms_pc          = $urandom;
         ms_ex          = ($urandom_range(0, 3) == 0);
         ms_excode      = 5'($urandom);
         ms_badvaddr    = $urandom;
         ms_bd          = 1'($urandom);
         ms_mtc0        = ($urandom_range(0, 3) == 0);
         ms_mfc0        = ($urandom_range(0, 3) == 0);
         ms_eret        = ($urandom_range(0, 7) == 0);
         ms_c0_addr     = 5'($urandom);
         ms_rt_value    = $urandom;
         ms_gr_we       = 1'($urandom);
         ms_dest        = 5'($urandom);
         ms_result      = $urandom;
         cp0_rdata      = $urandom;
         cp0_epc        = $urandom;
         cp0_status     = $urandom;
         cp0_cause      = $urandom;
         @(negedge clk);
         predict();
         chk($sformatf("rnd%0d_bus", i), bus, p_bus);
         chk($sformatf("rnd%0d_rf", i), {rf_we, rf_waddr, rf_wdata}, {p_rf_we, m.dest, p_rf_wdata});
         chk($sformatf("rnd%0d_flush", i), {ws_flush, ws_flush_pc}, {p_flush, p_fpc});
         chk($sformatf("rnd%0d_misc", i), {ws_allow_in, debug_wb_pc}, {!m_flushing, m.pc});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_exc_commit.md
Name: wb_exc_commit

Overview:
- Writeback-stage commit unit. It is the producer side of the WB-to-CP0 register bus consumed by the CP0 register file.
- It holds the WB pipeline register and merges in-flight exceptions with pending interrupts sampled from CP0. It then packs the exception, MTC0 and ERET request onto the bus.
- It drives the pipeline flush and the redirect PC.
- It returns register-file writeback, including MFC0 data read back from CP0.

Parameters:
- EX_VECTOR, 32'hBFC0_0380, exception entry PC (Status.BEV fixed at 1).
- WB_TO_CP0_REGISTER_BUS_WD, 110, bus width (from the shared header).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ms_to_ws_valid  in  1  MEM stage has an instruction
- ws_allow_in  out  1  WB accepts this cycle
- ms_pc  in  32  instruction PC
- ms_ex  in  1  exception raised upstream
- ms_excode  in  5  upstream exception code
- ms_badvaddr  in  32  faulting address
- ms_bd  in  1  instruction sits in a delay slot
- ms_mtc0 / ms_mfc0 / ms_eret  in  1 each  CP0 op flags
- ms_c0_addr  in  5  CP0 register number
- ms_rt_value  in  32  MTC0 source data
- ms_gr_we  in  1  writes the GPR file
- ms_dest  in  5  GPR destination
- ms_result  in  32  ALU/load result
- cp0_rdata  in  32  CP0 read data, addressed by c0_waddr on the bus
- cp0_epc  in  32  CP0 EPC
- cp0_status  in  32  Status readback
- cp0_cause  in  32  Cause readback
- wb_to_cp0_register_bus  out  110  {ex, excode[4:0], badvaddr[31:0], bd, pc[31:0], mtc0_we, c0_waddr[4:0], c0_wdata[31:0], eret_flush}, MSB first
- rf_we  out  1  GPR write enable
- rf_waddr  out  5  GPR write address
- rf_wdata  out  32  GPR write data
- ws_flush  out  1  flush IF..MEM
- ws_flush_pc  out  32  redirect target
- debug_wb_pc  out  32  PC of the committing instruction

Behaviour:
- Pipeline register
  - ws_valid register with 1-deep capture.
  - ws_allow_in = (state==RUN).
  - Capture on ms_to_ws_valid & ws_allow_in; otherwise ws_valid <= 0.
  - Every stage completes in one cycle; there is no back-pressure from CP0.
- Reset
  - ws_valid=0, state=RUN, all registered fields 0.
  - All outputs therefore read 0, except ws_allow_in=1.
- Interrupt detect (combinational, on CP0 readback)
  - int_pend = Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]).
  - Attached only to a valid WB instruction.
- Exception merge
  - take_ex = ws_valid & (int_pend | ws_ex).
  - Excode = 5'h00 (INT) if int_pend, else ws_excode. Interrupt has priority.
- Bus fields
  - ex = take_ex.
  - eret_flush = ws_valid & ws_eret & ~take_ex.
  - mtc0_we = ws_valid & ws_mtc0 & ~take_ex; c0_waddr = ws_c0_addr; c0_wdata = ws_rt_value.
  - badvaddr, bd and pc come straight from the WB register.
  - All fields are combinational from WB state. CP0 captures them at the next edge.
- Writeback
  - rf_we = ws_valid & ws_gr_we & ~take_ex.
  - rf_wdata = cp0_rdata when ws_mfc0, else ws_result.
  - debug_wb_pc = ws_pc.
- Flush
  - ws_flush = take_ex | eret_flush, asserted in the same cycle as the bus request.
  - ws_flush_pc = EX_VECTOR on take_ex; cp0_epc on eret; 0 otherwise.
- FSM
  - RUN -> FLUSH on ws_flush.
  - FLUSH -> RUN unconditionally after 1 cycle.
  - In FLUSH: ws_allow_in=0, so a younger instruction still presented by MEM is dropped. ws_valid=0 and no bus activity.
- Simultaneous events
  - ERET or MTC0 together with an exception or interrupt: the exception wins, and mtc0_we and eret are suppressed.
  - A reset asserted during FLUSH returns to RUN with ws_valid=0.

Decomposition:
- Shared header (mycpu.h) holds:
  - WB_TO_CP0_REGISTER_BUS_WD
  - EX_INT=0, EX_ADEL=4, EX_ADES=5, EX_SYS=8, EX_BP=9, EX_RI=10, EX_OV=12
  - CR_* register numbers
  - EX_VECTOR
- One sub-module, wb_int_detect: combinational int_pend and merged excode.

Test Plan:
- Reset, then plain ADDU (pc=0xBFC0_0010, dest=5, result=0x1234): one cycle later rf_we=1, rf_waddr=5, rf_wdata=0x1234, bus ex=0, ws_flush=0.
- Upstream SYSCALL (excode=8, pc=0xBFC0_0020, bd=1): bus ex=1, excode=8, bd=1, pc=0xBFC0_0020; ws_flush=1, ws_flush_pc=0xBFC0_0380, rf_we=0. The next cycle ws_allow_in=0 and a MEM-presented instruction is dropped.
- ERET with cp0_epc=0xBFC0_1000: eret_flush=1, ws_flush_pc=0xBFC0_1000, followed by a single FLUSH cycle.
- Status=0x0000_8001, Cause=0x0000_8000 with an MTC0 in WB: excode=0, ex=1, mtc0_we=0. With Status[1]=1 instead: no interrupt and mtc0_we=1.
- MFC0 from COUNT (c0_addr=9, cp0_rdata=0x55): rf_wdata=0x55, bus c0_waddr=9, mtc0_we=0.
- Reset asserted in the FLUSH cycle: the next cycle state=RUN, ws_allow_in=1, all bus fields 0.
